// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone-style slave arbiter.
package wb_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int unsigned ARB_DEFAULT_TIMEOUT = 255;
    localparam int unsigned ARB_ERR_RDATA       = 0;

endpackage

// File: rtl/wb_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester after last_grant, wrapping modulo N.
module rr_picker #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    output logic                 valid,
    output logic [$clog2(N)-1:0] grant
);

    localparam int IDX_W = $clog2(N);

    always_comb begin
        valid = 1'b0;
        grant = '0;
        // k = N revisits last_grant itself, so a lone repeat requester still wins
        for (int k = 1; k <= N; k++) begin
            if (!valid && req[(int'(last_grant) + k) % N]) begin
                valid = 1'b1;
                grant = IDX_W'((int'(last_grant) + k) % N);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone-style slave between NUM_MASTERS masters,
// one transaction per grant, with registered slave outputs and a timeout watchdog.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int          NUM_MASTERS = 2,
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter int unsigned TIMEOUT     = ARB_DEFAULT_TIMEOUT
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [NUM_MASTERS-1:0]        M_cs,
    input  logic [NUM_MASTERS-1:0]        M_we,
    input  logic [NUM_MASTERS*ADDR_W-1:0] M_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0] M_wdata,
    output logic [DATA_W-1:0]             M_rdata,
    output logic [NUM_MASTERS-1:0]        M_ack,
    output logic [NUM_MASTERS-1:0]        M_err,
    output logic [ADDR_W-1:0]             Wb_addr,
    output logic                          Wb_cs,
    output logic                          Wb_we,
    output logic [DATA_W-1:0]             Wb_wdata,
    input  logic [DATA_W-1:0]             Wb_rdata,
    input  logic                          Wb_ack,
    output arb_state_t                    Dbg_state
);

    localparam int IDX_W  = $clog2(NUM_MASTERS);
    localparam int WDOG_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT);

    // Handshake: a master raises M_cs with addr/we/wdata stable and holds them until
    // it sees its one-cycle M_ack; the slave likewise sees Wb_cs held until Wb_ack.
    arb_state_t        state;
    logic [IDX_W-1:0]  grant;
    logic [IDX_W-1:0]  last_grant;
    logic [WDOG_W-1:0] wdog;

    logic              pick_valid;
    logic [IDX_W-1:0]  pick;
    logic              busy;
    logic              expire;
    logic              done_ok;
    logic              done_to;

    rr_picker #(
        .N(NUM_MASTERS)
    ) u_picker (
        .req        (M_cs),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .grant      (pick)
    );

    assign busy      = (state == ARB_BUSY) && !Rst;
    assign expire    = (TIMEOUT != 0) && (wdog == WDOG_MAX);
    assign done_ok   = busy && Wb_ack;
    assign done_to   = busy && !Wb_ack && expire;
    assign Dbg_state = state;

    always_comb begin
        M_ack   = '0;
        M_err   = '0;
        M_rdata = DATA_W'(ARB_ERR_RDATA);
        if (done_ok) begin
            M_ack[grant] = 1'b1;
            M_rdata      = Wb_rdata;
        end else if (done_to) begin
            M_ack[grant] = 1'b1;
            M_err[grant] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(NUM_MASTERS - 1);
            wdog       <= '0;
            Wb_cs      <= 1'b0;
            Wb_we      <= 1'b0;
            Wb_addr    <= '0;
            Wb_wdata   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        Wb_addr    <= M_addr[int'(pick) * ADDR_W +: ADDR_W];
                        Wb_wdata   <= M_wdata[int'(pick) * DATA_W +: DATA_W];
                        Wb_we      <= M_we[pick];
                        Wb_cs      <= 1'b1;
                        grant      <= pick;
                        last_grant <= pick;
                        wdog       <= '0;
                        state      <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (done_ok || done_to) begin
                        Wb_cs <= 1'b0;
                        state <= ARB_IDLE;
                    end else if (TIMEOUT != 0 && wdog != WDOG_MAX) begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: begin
                    Wb_cs <= 1'b0;
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares one Wishbone-style memory slave between NUM_MASTERS requesters, e.g. the core's data port and a DMA/debug master.
- Round-robin arbitration; each grant is held for exactly one transaction (cs ... ack).
- Slave-side outputs are registered.
- A watchdog completes hung transactions with an error so no master stalls forever.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- ADDR_W, 32, address width (matches the shared ADDR_SIZE define).
- DATA_W, 32, data width (matches the shared WORD_SIZE define).
- TIMEOUT, 255, slave cycles allowed before error-completion; 0 disables the watchdog.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Rst  in  1  synchronous, active-high reset.
- M_cs  in  NUM_MASTERS  per-master request; held high with addr/we/wdata stable until its ack.
- M_we  in  NUM_MASTERS  per-master write enable.
- M_addr  in  NUM_MASTERS*ADDR_W  flattened addresses; master i occupies slice i.
- M_wdata  in  NUM_MASTERS*DATA_W  flattened write data.
- M_rdata  out  DATA_W  read data, broadcast to all masters; valid only with that master's ack.
- M_ack  out  NUM_MASTERS  one-cycle completion pulse, one-hot.
- M_err  out  NUM_MASTERS  one-cycle error flag, asserted only together with M_ack (timeout).
- Wb_addr  out  ADDR_W  slave address (registered).
- Wb_cs  out  1  slave chip select (registered).
- Wb_we  out  1  slave write enable (registered).
- Wb_wdata  out  DATA_W  slave write data (registered).
- Wb_rdata  in  DATA_W  slave read data.
- Wb_ack  in  1  slave completion pulse.

Behaviour:
- Reset values:
  - Outputs: Wb_cs=0, Wb_we=0, Wb_addr=0, Wb_wdata=0, M_ack=0, M_err=0, M_rdata=0.
  - State: state=IDLE, grant=0, last_grant=NUM_MASTERS-1 (master 0 wins first), wdog=0.
- States: IDLE, BUSY.
- IDLE:
  - If any M_cs is high, pick the first requester scanning last_grant+1, last_grant+2, ... with wrap modulo NUM_MASTERS.
  - At the edge: latch that master's addr/we/wdata into the Wb_* registers, set Wb_cs=1, grant=i, last_grant=i, wdog=0, go to BUSY.
  - If no M_cs is high, stay in IDLE with Wb_cs=0.
- BUSY, normal completion (Wb_ack=1):
  - Same cycle, combinationally: M_ack[grant]=1, M_rdata=Wb_rdata.
  - Next edge: Wb_cs=0, go to IDLE.
- BUSY, timeout (Wb_ack=0, TIMEOUT!=0, wdog==TIMEOUT):
  - Same cycle: M_ack[grant]=1, M_err[grant]=1, M_rdata=0.
  - Next edge: Wb_cs=0, go to IDLE.
- BUSY, otherwise: wdog increments, saturating at TIMEOUT.
- If Wb_ack arrives in the same cycle the watchdog expires, Wb_ack wins: normal completion, M_err=0.
- Latency:
  - Request seen in IDLE in cycle 0: Wb_cs high in cycle 1.
  - Ack in cycle k: Wb_cs low in cycle k+1; the earliest next grant has Wb_cs high in cycle k+2.
  - Minimum spacing between transactions is therefore 1 idle cycle.
- A master dropping M_cs while granted is a protocol violation. The arbiter ignores it and completes the transaction normally.
- Requests from non-granted masters are held pending, never lost. Each waits at most NUM_MASTERS-1 transactions.
- M_ack is zero outside BUSY. A stale Wb_ack seen in IDLE is ignored.
- Reset mid-transaction: Wb_cs drops at the next edge, no M_ack is generated, and arbitration restarts with master 0 priority.
- Widths:
  - wdog is clog2(TIMEOUT+1) bits; at least 1 bit when TIMEOUT=0.
  - grant and last_grant are clog2(NUM_MASTERS) bits.

Decomposition:
- Shared package wb_arb_pkg holds:
  - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t.
  - Default constants ARB_DEFAULT_TIMEOUT=255 and ARB_ERR_RDATA=0.
- One sub-module: rr_picker.
  - Purely combinational.
  - Inputs: request vector, last_grant.
  - Outputs: valid, grant index.
  - Reusable by future interrupt or DMA-channel schedulers.

Test Plan:
- Single read: master 0 cs=1, addr=0x100, we=0; slave acks in cycle 3 with rdata=0xCAFEF00D -> Wb_cs high cycles 1..3, Wb_addr=0x100, M_ack[0] pulse in cycle 3, M_rdata=0xCAFEF00D, Wb_cs low in cycle 4.
- Contention after reset: masters 0 and 1 both raise cs in cycle 0; master 0 writes 0x11 to 0x20, master 1 writes 0x22 to 0x24 -> slave sees master 0's write first, then master 1's, with exactly one idle cycle between them.
- Fairness: both masters request continuously for 6 transactions -> grant order 0,1,0,1,0,1; no M_ack ever has two bits set.
- Timeout, TIMEOUT=16: slave never acks -> M_ack[g]=1, M_err[g]=1, M_rdata=0 exactly 16 cycles after the Wb_cs rising edge; Wb_cs low on the next cycle.
- Ack/timeout tie: slave acks in exactly the expiry cycle with rdata=0x5 -> M_ack=1, M_err=0, M_rdata=0x5.
- Reset mid-transaction: Rst pulsed in cycle 2 of master 1's transaction -> Wb_cs=0 next cycle, no M_ack; with both masters then requesting, master 0 is granted first.
